systolic_drain: RTL and testbench
=================================

Name: systolic_drain

Overview:
- Drain controller at the result end of the systolic MAC array. It is the reader of the per-PE accumulator drain interface (drain_en / acc_out / acc_out_valid / acc_clear_block).
- After a C-block finishes, it walks the ROWS x COLS PEs in row-major order. For each PE it asserts that PE's drain_en, captures its accumulator, optionally saturates it to OUT_W, and emits it on a valid/ready stream.
- When the walk completes, it pulses acc_clear_block to the whole array.

Parameters:
- ROWS, 4, PE rows in array (>=1)
- COLS, 4, PE columns in array (>=1)
- ACCW, 32, PE accumulator width
- OUT_W, 32, output data width; must be <= ACCW (elaboration $error otherwise)
- SIGNED, 1, 1 = signed saturation when narrowing, 0 = unsigned
- TIMEOUT, 15, max cycles to wait for a PE's acc_out_valid before forcing progress (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  1-cycle pulse: C-block compute finished, begin drain
- acc_in  in  ROWS*COLS*ACCW  flattened PE acc_out; PE k at bits [k*ACCW +: ACCW], with k = r*COLS + c
- acc_valid_in  in  ROWS*COLS  PE acc_out_valid, one bit per PE
- drain_en  out  ROWS*COLS  one-hot (or zero) drain select to PEs
- acc_clear_block  out  1  1-cycle clear pulse to all PEs
- m_data  out  OUT_W  result element
- m_row  out  $clog2(ROWS) (min 1)  row index of m_data
- m_col  out  $clog2(COLS) (min 1)  column index of m_data
- m_last  out  1  marks final element of block
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  1-cycle pulse coincident with acc_clear_block
- err  out  1  sticky: some PE timed out this block; cleared on next accepted start

Behaviour:
- Reset (async, rst=1): state IDLE, idx=0, wait counter 0. All outputs 0: drain_en, acc_clear_block, m_* (data/row/col/last/valid), busy, done, err. Reset mid-drain abandons the block; no clear pulse is issued.
- Registered outputs throughout, except drain_en, which is decoded combinationally from the state register and idx.
- IDLE: start=1 -> clear err, idx=0, wait counter 0, go DRAIN.
- DRAIN:
  - drain_en[idx]=1; all other bits 0.
  - If acc_valid_in[idx]=1: register sat(acc_in[idx]) into m_data, plus m_row=idx/COLS, m_col=idx%COLS, m_last=(idx==ROWS*COLS-1). Set m_valid=1 next cycle; go SEND.
  - Else if wait counter == TIMEOUT: same capture, but m_data=0; set err=1; go SEND.
  - Else: increment wait counter.
- SEND:
  - drain_en=0.
  - m_data/m_row/m_col/m_last stay stable while m_valid=1 and m_ready=0. m_valid is never dropped without a handshake.
  - On m_valid & m_ready: m_valid=0. If m_last, go CLEAR; else idx++, wait counter 0, go DRAIN.
- CLEAR: acc_clear_block=1 and done=1 for exactly this one cycle; go IDLE.
- busy = (state != IDLE).
- Latency: start -> first m_valid is 2 cycles minimum (start in cycle 0, DRAIN in cycle 1, m_valid in cycle 2). Steady state is one element per 2 cycles with m_ready tied high.
- start while busy is ignored: no restart, no err clear.
- Saturation (OUT_W < ACCW):
  - SIGNED=1: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - SIGNED=0: clamp to 2^OUT_W - 1, treating acc_in as unsigned.
  - OUT_W == ACCW: pass-through.
- ROWS*COLS == 1: idx never increments; m_last is always 1.

Decomposition:
- Package systolic_pkg holds:
  - drain_state_e enum (IDLE, DRAIN, SEND, CLEAR)
  - a localparam function for index width (max(1, $clog2(n)))
  - shared defaults ACCW_DEF=32, W_DEF=8
- One sub-module: sat_narrow (combinational, params IN_W, OUT_W, SIGNED) implements the clamp. Instantiated once, on the selected acc_in slice.

Test Plan:
1. 2x2 array, ACCW=OUT_W=32, PE model raises acc_valid_in one cycle after drain_en, accs {5,-3,100,0}, m_ready=1 -> four beats in order (0,0)=5, (0,1)=-3, (1,0)=100, (1,1)=0; m_last only on beat 4; one acc_clear_block/done pulse after beat 4; busy falls with it.
2. Backpressure: m_ready low for 5 cycles on beat 2 -> m_valid held and m_data/m_row/m_col unchanged throughout; drain_en stays 0 during the stall; no element lost or duplicated.
3. Saturation: OUT_W=16, SIGNED=1, accs {70000, -70000, 1234} -> m_data {32767, -32768, 1234}. With SIGNED=0 and acc 0x0001_0000 -> 65535.
4. Timeout: PE (1,0) never asserts valid, TIMEOUT=15 -> its beat is emitted with data 0 after 16 waiting cycles; err=1 and stays 1 after done; next start clears err.
5. start pulsed mid-drain -> ignored; sequence completes unchanged.
6. rst asserted during SEND of beat 2 -> all outputs 0 immediately, no clear pulse; a fresh start restarts at (0,0).

Source files
------------

// File: rtl/systolic_drain_pkg.sv
// systolic_pkg: shared FSM states, defaults and index-width helper for the drain controller
package systolic_pkg;
    typedef enum logic [1:0] {IDLE, DRAIN, SEND, CLEAR} drain_state_e;
    localparam int ACCW_DEF = 32;
    localparam int W_DEF = 8;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/systolic_drain_if.sv
// systolic_drain_if: tagged valid/ready result stream leaving the drain controller
interface systolic_drain_if #(parameter int OUT_W = 32, RW = 1, CW = 1);
    logic [OUT_W-1:0] m_data;
    logic [RW-1:0] m_row;
    logic [CW-1:0] m_col;
    logic m_last;
    logic m_valid;
    logic m_ready;
    modport master(output m_data, m_row, m_col, m_last, m_valid, input m_ready);
    modport slave(input m_data, m_row, m_col, m_last, m_valid, output m_ready);
endinterface

// File: rtl/systolic_drain_sat_narrow.sv
// sat_narrow: clamps a wide accumulator into a narrower signed or unsigned range
module sat_narrow
    import systolic_pkg::*;
#(
    parameter int IN_W = ACCW_DEF,
    parameter int OUT_W = W_DEF,
    parameter int SIGNED = 1
)(
    input  logic [IN_W-1:0]  i_in,
    output logic [OUT_W-1:0] o_out
);
    if (OUT_W == IN_W) begin : g_pass
        assign o_out = i_in;
    end else if (SIGNED != 0) begin : g_signed
        localparam logic [OUT_W-1:0] SMIN = OUT_W'(1) << (OUT_W - 1);
        logic [IN_W-OUT_W:0] w_hi;
        // value fits only when every bit from the new sign bit upward agrees
        assign w_hi = i_in[IN_W-1:OUT_W-1];
        assign o_out = (!i_in[IN_W-1] && |w_hi) ? ~SMIN :
                       (i_in[IN_W-1] && !(&w_hi)) ? SMIN : i_in[OUT_W-1:0];
    end else begin : g_unsigned
        assign o_out = |i_in[IN_W-1:OUT_W] ? '1 : i_in[OUT_W-1:0];
    end
endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: walks the PE accumulators row-major, streams each one out narrowed, then clears the array
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int ACCW = ACCW_DEF,
    parameter int OUT_W = 32,
    parameter int SIGNED = 1,
    parameter int TIMEOUT = 15
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ROWS*COLS*ACCW-1:0] acc_in,
    input  logic [ROWS*COLS-1:0]      acc_valid_in,
    output logic [ROWS*COLS-1:0]      drain_en,
    output logic                      acc_clear_block,
    systolic_drain_if.master          m,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam int N = ROWS * COLS;
    localparam int IW = idx_w(N);
    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);
    localparam int TW = idx_w(TIMEOUT + 1);

    if (OUT_W > ACCW) begin : g_chk
        $error("systolic_drain: OUT_W must not exceed ACCW");
    end

    drain_state_e r_state, w_next;
    logic [IW-1:0] r_idx;
    logic [TW-1:0] r_wait;
    logic [OUT_W-1:0] w_sat;
    logic w_valid, w_timeout, w_capture, w_hs;

    assign w_valid = acc_valid_in[r_idx];
    assign w_timeout = r_wait == TW'(TIMEOUT);
    assign w_capture = r_state == DRAIN && (w_valid || w_timeout);
    assign w_hs = r_state == SEND && m.m_valid && m.m_ready;
    assign drain_en = r_state == DRAIN ? N'(1) << r_idx : '0;
    assign acc_clear_block = done;

    sat_narrow #(.IN_W(ACCW), .OUT_W(OUT_W), .SIGNED(SIGNED)) u_sat (
        .i_in (acc_in[int'(r_idx)*ACCW +: ACCW]),
        .o_out(w_sat)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? DRAIN : IDLE;
            DRAIN:   w_next = w_capture ? SEND : DRAIN;
            SEND:    w_next = w_hs ? (m.m_last ? CLEAR : DRAIN) : SEND;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else r_state <= w_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            r_wait <= '0;
            m.m_data <= '0;
            m.m_row <= '0;
            m.m_col <= '0;
            m.m_last <= 1'b0;
            m.m_valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
        end else begin
            busy <= w_next != IDLE;
            done <= w_next == CLEAR;
            if (r_state == IDLE && start) begin
                r_idx <= '0;
                r_wait <= '0;
                err <= 1'b0;
            end
            if (w_capture) begin
                m.m_data <= w_valid ? w_sat : '0;
                m.m_row <= RW'(int'(r_idx) / COLS);
                m.m_col <= CW'(int'(r_idx) % COLS);
                m.m_last <= r_idx == IW'(N - 1);
                m.m_valid <= 1'b1;
                if (!w_valid) err <= 1'b1;
            end else if (r_state == DRAIN) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_hs) begin
                m.m_valid <= 1'b0;
                if (!m.m_last) begin
                    r_idx <= r_idx + 1'b1;
                    r_wait <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: directed checks of the drain walk, backpressure, saturation, timeout and reset
module tb_systolic_drain;
    import systolic_pkg::*;
    localparam int N = 4;
    typedef struct { logic [31:0] d; int r; int c; bit last; } beat_t;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    int checks = 0, errors = 0;

    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;

    logic [N*32-1:0] acc0;
    logic [N-1:0] av0, de0, stuck;
    logic clr0, busy0, done0, err0;
    systolic_drain_if #(.OUT_W(32), .RW(1), .CW(1)) s0 ();
    systolic_drain #(.ROWS(2), .COLS(2), .ACCW(32), .OUT_W(32), .SIGNED(1), .TIMEOUT(15)) u0 (
        .clk(clk), .rst(rst), .start(start0), .acc_in(acc0), .acc_valid_in(av0), .drain_en(de0),
        .acc_clear_block(clr0), .m(s0.master), .busy(busy0), .done(done0), .err(err0));

    logic [N*32-1:0] acc1 = {-32'sd5, 32'sd1234, -32'sd70000, 32'sd70000};
    logic [N-1:0] av1 = '1;
    logic [N-1:0] de1;
    logic clr1, busy1, done1, err1;
    systolic_drain_if #(.OUT_W(16), .RW(1), .CW(1)) s1 ();
    systolic_drain #(.ROWS(2), .COLS(2), .ACCW(32), .OUT_W(16), .SIGNED(1), .TIMEOUT(15)) u1 (
        .clk(clk), .rst(rst), .start(start1), .acc_in(acc1), .acc_valid_in(av1), .drain_en(de1),
        .acc_clear_block(clr1), .m(s1.master), .busy(busy1), .done(done1), .err(err1));

    logic [31:0] acc2 = 32'h0001_0000;
    logic [0:0] av2 = 1'b1;
    logic [0:0] de2;
    logic clr2, busy2, done2, err2;
    systolic_drain_if #(.OUT_W(16), .RW(1), .CW(1)) s2 ();
    systolic_drain #(.ROWS(1), .COLS(1), .ACCW(32), .OUT_W(16), .SIGNED(0), .TIMEOUT(15)) u2 (
        .clk(clk), .rst(rst), .start(start2), .acc_in(acc2), .acc_valid_in(av2), .drain_en(de2),
        .acc_clear_block(clr2), .m(s2.master), .busy(busy2), .done(done2), .err(err2));

    // PE model: acc_out_valid follows drain_en one cycle later unless the PE is stuck
    always @(posedge clk or posedge rst)
        if (rst) av0 <= '0;
        else av0 <= de0 & ~stuck;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    logic [31:0] accv [N];
    beat_t expq[$];
    logic [31:0] got[$];
    logic [15:0] d1[$];

    task automatic load(input logic [31:0] a0, a1, a2, a3, input logic [N-1:0] st);
        accv = '{a0, a1, a2, a3};
        stuck = st;
        for (int k = 0; k < N; k++) begin
            acc0[k*32 +: 32] = accv[k];
            expq.push_back('{stuck[k] ? 32'd0 : accv[k], k / 2, k % 2, k == N - 1});
        end
    endtask

    logic held = 1'b0;
    int beats = 0, dones = 0, stalls = 0, de2cyc = 0;
    always @(negedge clk) begin
        if (rst) held = 1'b0;
        else begin
            chk("drain_en_onehot", $countones(de0) <= 1, 1);
            if (de0[2]) de2cyc++;
            if (held) chk("valid_held", s0.m_valid, 1);
            if (s0.m_valid) begin
                chk("drain_en_in_send", de0, 0);
                if (expq.size() == 0) chk("beat_expected", expq.size(), 1);
                else begin
                    chk("m_data", s0.m_data, expq[0].d);
                    chk("m_row", s0.m_row, expq[0].r);
                    chk("m_col", s0.m_col, expq[0].c);
                    chk("m_last", s0.m_last, expq[0].last);
                    if (s0.m_ready) begin
                        void'(expq.pop_front());
                        got.push_back(s0.m_data);
                        beats++;
                    end else stalls++;
                end
            end
            if (done0) begin
                dones++;
                chk("clear_with_done", clr0, 1);
                chk("queue_drained", expq.size(), 0);
                chk("busy_at_done", busy0, 1);
            end else chk("no_stray_clear", clr0, 0);
            held = s0.m_valid && !s0.m_ready;
        end
    end

    always @(negedge clk) if (!rst && s1.m_valid) d1.push_back(s1.m_data);

    task automatic pulse(input int w);
        @(posedge clk); #1;
        if (w == 0) start0 = 1'b1; else if (w == 1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        for (int i = 0; i < budget && !done0; i++) @(negedge clk);
        chk(nm, done0, 1);
        @(negedge clk);
    endtask

    task automatic reset_counts();
        beats = 0; dones = 0; stalls = 0; de2cyc = 0;
        got.delete();
    endtask

    int lat;
    initial begin
        s0.m_ready = 1'b1; s1.m_ready = 1'b1; s2.m_ready = 1'b1;
        stuck = '0; acc0 = '0;
        repeat (2) @(posedge clk); #1;
        chk("rst_drain_en", de0, 0); chk("rst_valid", s0.m_valid, 0); chk("rst_data", s0.m_data, 0);
        chk("rst_busy", busy0, 0); chk("rst_done", done0, 0); chk("rst_err", err0, 0); chk("rst_clear", clr0, 0);
        rst = 1'b0;

        reset_counts();
        load(32'd5, -32'sd3, 32'd100, 32'd0, 4'b0000);
        pulse(0);
        wait_done("t1_done", 100);
        chk("t1_beats", beats, 4); chk("t1_dones", dones, 1); chk("t1_busy_low", busy0, 0); chk("t1_err", err0, 0);
        chk("t1_b0", got[0], 32'd5); chk("t1_b1", got[1], 32'hffff_fffd); chk("t1_b2", got[2], 32'd100);

        reset_counts();
        load(32'd11, 32'd22, 32'd33, 32'd44, 4'b0000);
        pulse(0);
        for (int i = 0; i < 50 && beats < 1; i++) @(negedge clk);
        @(posedge clk); #1 s0.m_ready = 1'b0;
        for (int i = 0; i < 50 && !s0.m_valid; i++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1 s0.m_ready = 1'b1;
        wait_done("t2_done", 100);
        chk("t2_beats", beats, 4); chk("t2_stalls", stalls, 5); chk("t2_dones", dones, 1);
        chk("t2_b1", got[1], 32'd22); chk("t2_b3", got[3], 32'd44);

        reset_counts();
        load(32'd1, 32'd2, 32'd3, 32'd4, 4'b0100);
        pulse(0);
        for (int i = 0; i < 100 && beats < 3; i++) @(negedge clk);
        chk("t4_err_set", err0, 1);
        pulse(0);
        chk("t5_err_kept", err0, 1);
        wait_done("t4_done", 100);
        chk("t4_beats", beats, 4); chk("t4_dones", dones, 1); chk("t4_wait", de2cyc, 16);
        chk("t4_b2_zero", got[2], 32'd0); chk("t4_b3", got[3], 32'd4); chk("t4_busy_low", busy0, 0);
        repeat (3) @(negedge clk);
        chk("t4_err_sticky", err0, 1);

        reset_counts();
        load(32'd9, 32'd8, 32'd7, 32'd6, 4'b0000);
        pulse(0);
        @(negedge clk);
        chk("t4_err_cleared", err0, 0);
        wait_done("t4b_done", 100);
        chk("t4b_beats", beats, 4);

        reset_counts();
        load(32'd7, 32'd8, 32'd9, 32'd10, 4'b0000);
        pulse(0);
        for (int i = 0; i < 50 && beats < 1; i++) @(negedge clk);
        @(posedge clk); #1 s0.m_ready = 1'b0;
        for (int i = 0; i < 50 && !s0.m_valid; i++) @(negedge clk);
        chk("t6_in_send", s0.m_data, 32'd8);
        @(posedge clk); #1 rst = 1'b1;
        expq.delete();
        #1;
        chk("t6_valid", s0.m_valid, 0); chk("t6_data", s0.m_data, 0); chk("t6_col", s0.m_col, 0);
        chk("t6_last", s0.m_last, 0); chk("t6_de", de0, 0); chk("t6_busy", busy0, 0);
        chk("t6_done", done0, 0); chk("t6_clr", clr0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; s0.m_ready = 1'b1;
        chk("t6_no_clear", dones, 0); chk("t6_beats_before", beats, 1);
        reset_counts();
        load(32'd21, 32'd22, 32'd23, 32'd24, 4'b0000);
        pulse(0);
        wait_done("t6_done", 100);
        chk("t6_restart_b0", got[0], 32'd21); chk("t6_restart_beats", beats, 4); chk("t6_dones", dones, 1);

        d1.delete();
        pulse(1);
        for (int i = 0; i < 100 && !done1; i++) @(negedge clk);
        chk("sat_done", done1, 1);
        chk("sat_n", d1.size(), 4);
        chk("sat_pos", d1[0], 16'h7fff); chk("sat_neg", d1[1], 16'h8000);
        chk("sat_pass", d1[2], 16'd1234); chk("sat_small_neg", d1[3], 16'hfffb);

        pulse(2);
        for (lat = 1; lat < 20; lat++) begin
            @(negedge clk);
            if (s2.m_valid) break;
        end
        chk("u_latency", lat, 2);
        chk("u_sat", s2.m_data, 16'hffff); chk("u_last", s2.m_last, 1);
        chk("u_row", s2.m_row, 0); chk("u_col", s2.m_col, 0);
        for (int i = 0; i < 20 && !done2; i++) @(negedge clk);
        chk("u_done", done2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
